// File: rtl/operand_fetch_pkg.sv
// Shared types and widths for the operand-fetch stage.
//   XLEN       : default register data width
//   REG_ADDR_W : architectural register address width
//   state_t    : operand-fetch FSM state
//   instr_t    : latched instruction register fields
package operand_fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      rd_wen;
    } instr_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode -> operand-fetch -> execute handshake bundle.
//   in_*  : decoded instruction from decode (valid/ready)
//   out_* : fetched operands to execute (valid/ready)
//   master: the decode/execute side; slave: operand_fetch
interface operand_fetch_if #(
    parameter int unsigned XLEN = operand_fetch_pkg::XLEN
);
    logic                          in_valid;
    logic                          in_ready;
    operand_fetch_pkg::reg_addr_t  in_rs1;
    operand_fetch_pkg::reg_addr_t  in_rs2;
    operand_fetch_pkg::reg_addr_t  in_rd;
    logic                          in_rd_wen;

    logic                          out_valid;
    logic                          out_ready;
    logic [XLEN-1:0]               out_rs1_val;
    logic [XLEN-1:0]               out_rs2_val;
    operand_fetch_pkg::reg_addr_t  out_rd;
    logic                          out_rd_wen;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
        input  in_ready,
        input  out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_wen,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
        output in_ready,
        output out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_wen,
        input  out_ready
    );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
//   set_en/set_addr : mark a register as awaiting writeback
//   clr_en/clr_addr : writeback completes for a register
//   query_*/busy_*  : pending status, already treating a same-cycle clear
//                     as done; a same-cycle set of the same register wins
module scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t query_a,
    input  reg_addr_t query_b,
    input  reg_addr_t query_c,
    output logic      busy_a,
    output logic      busy_b,
    output logic      busy_c
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_n;

    // Set is applied after clear so it wins; x0 never becomes pending.
    always_comb begin
        pending_n = pending;
        if (clr_en) pending_n[clr_addr] = 1'b0;
        if (set_en) pending_n[set_addr] = 1'b1;
        pending_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_n;
    end

    assign busy_a = pending[query_a] && !(clr_en && clr_addr == query_a);
    assign busy_b = pending[query_b] && !(clr_en && clr_addr == query_b);
    assign busy_c = pending[query_c] && !(clr_en && clr_addr == query_c);

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches a decoded instruction, waits out RAW/WAW
// hazards against the pending-write scoreboard, reads the register file
// (with writeback bypass) and holds the operands until execute takes them.
//   clk, rst_n   : clock, async active-low reset
//   bus          : decode/execute handshake (slave side)
//   wb_*         : writeback request from execute
//   rf_read_*    : combinational register-file read ports
//   rf_write_*   : register-file write port (commits on posedge clk)
module operand_fetch #(
    parameter int unsigned XLEN = operand_fetch_pkg::XLEN,
    parameter int unsigned NREG = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    operand_fetch_if.slave               bus,
    input  logic                         wb_valid,
    input  operand_fetch_pkg::reg_addr_t wb_rd,
    input  logic [XLEN-1:0]              wb_data,
    output operand_fetch_pkg::reg_addr_t rf_read_address_1,
    output operand_fetch_pkg::reg_addr_t rf_read_address_2,
    input  logic [XLEN-1:0]              rf_read_data_1,
    input  logic [XLEN-1:0]              rf_read_data_2,
    output operand_fetch_pkg::reg_addr_t rf_write_address,
    output logic [XLEN-1:0]              rf_write_value,
    output logic                         rf_write_enable
);
    import operand_fetch_pkg::*;

    state_t          state, state_n;
    instr_t          ir, ir_n, in_instr;
    logic            out_valid_n, out_rd_wen_n;
    logic [XLEN-1:0] out_rs1_n, out_rs2_n, op1, op2;
    reg_addr_t       out_rd_n;
    logic            set_en, busy_rs1, busy_rs2, busy_rd, hazard;

    scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_addr (ir.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .query_a  (ir.rs1),
        .query_b  (ir.rs2),
        .query_c  (ir.rd),
        .busy_a   (busy_rs1),
        .busy_b   (busy_rs2),
        .busy_c   (busy_rd)
    );

    assign in_instr = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd, rd_wen: bus.in_rd_wen};
    assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign hazard = busy_rs1 || busy_rs2 || (ir.rd_wen && busy_rd);

    assign rf_read_address_1 = ir.rs1;
    assign rf_read_address_2 = ir.rs2;
    assign rf_write_enable   = wb_valid && (wb_rd != '0);
    assign rf_write_address  = wb_rd;
    assign rf_write_value    = wb_data;

    // A same-cycle writeback has not reached the file yet, so forward it.
    assign op1 = (wb_valid && wb_rd == ir.rs1 && ir.rs1 != '0) ? wb_data :
                 (ir.rs1 == '0) ? '0 : rf_read_data_1;
    assign op2 = (wb_valid && wb_rd == ir.rs2 && ir.rs2 != '0) ? wb_data :
                 (ir.rs2 == '0) ? '0 : rf_read_data_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ir              <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_rs1_val <= '0;
            bus.out_rs2_val <= '0;
            bus.out_rd      <= '0;
            bus.out_rd_wen  <= 1'b0;
        end else begin
            state           <= state_n;
            ir              <= ir_n;
            bus.out_valid   <= out_valid_n;
            bus.out_rs1_val <= out_rs1_n;
            bus.out_rs2_val <= out_rs2_n;
            bus.out_rd      <= out_rd_n;
            bus.out_rd_wen  <= out_rd_wen_n;
        end
    end

    // Next state and registered outputs.
    always_comb begin
        state_n      = state;
        ir_n         = ir;
        out_valid_n  = bus.out_valid;
        out_rs1_n    = bus.out_rs1_val;
        out_rs2_n    = bus.out_rs2_val;
        out_rd_n     = bus.out_rd;
        out_rd_wen_n = bus.out_rd_wen;
        set_en       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    ir_n    = in_instr;
                    state_n = STALL;
                end
            end
            STALL: begin
                if (!hazard) begin
                    out_valid_n  = 1'b1;
                    out_rs1_n    = op1;
                    out_rs2_n    = op2;
                    out_rd_n     = ir.rd;
                    out_rd_wen_n = ir.rd_wen;
                    set_en       = ir.rd_wen && (ir.rd != '0);
                    state_n      = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    if (bus.in_valid) begin
                        ir_n    = in_instr;
                        state_n = STALL;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; address width 5.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): decoded-instruction handshake.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd (input, 5 each) and in_rd_wen (input, 1): instruction register fields.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): operand handshake to execute.
REQ-008 SHALL have ports out_rs1_val, out_rs2_val (output, XLEN), out_rd (output, 5) and out_rd_wen (output, 1).
REQ-009 SHALL have ports wb_valid (input, 1), wb_rd (input, 5) and wb_data (input, XLEN): writeback request from execute.
REQ-010 SHALL have ports rf_read_address_1, rf_read_address_2 (output, 5) and rf_read_data_1, rf_read_data_2 (input, XLEN): register-file read ports, combinational read.
REQ-011 SHALL have ports rf_write_address (output, 5), rf_write_value (output, XLEN) and rf_write_enable (output, 1): register-file write port; the file commits on posedge clk.

Function
REQ-012 SHALL keep a pending[NREG-1:0] scoreboard; pending[0] SHALL always read 0.
REQ-013 SHALL implement FSM IDLE, STALL, HOLD.
REQ-014 SHALL set in_ready = 1 in IDLE, and in HOLD when out_ready = 1; otherwise 0.
REQ-015 On in_valid && in_ready, SHALL latch rs1/rs2/rd/rd_wen into an internal instruction register and enter STALL.
REQ-016 SHALL drive rf_read_address_1/2 from the latched rs1/rs2 in STALL.
REQ-017 In STALL, hazard = pending[rs1] || pending[rs2] || (rd_wen && pending[rd]); a source or destination cleared by this cycle's wb_valid SHALL count as not pending.
REQ-018 In STALL with no hazard, SHALL register operands, set out_valid, and enter HOLD.
REQ-018a Under REQ-018, the operand for a source SHALL be wb_data when wb_valid && wb_rd == rs && rs != 0 (bypass), else 0 when rs == 0, else rf_read_data.
REQ-018b Under REQ-018, pending[rd] SHALL be set when rd_wen && rd != 0.
REQ-019 Minimum latency: accept at edge N, out_valid high after edge N+1.
REQ-020 In HOLD, outputs SHALL stay stable until out_ready. On out_ready with in_valid, SHALL accept the next instruction and go to STALL; on out_ready without in_valid, SHALL go to IDLE.
REQ-021 wb_valid SHALL drive rf_write_enable = wb_valid && wb_rd != 0 combinationally, with rf_write_address = wb_rd and rf_write_value = wb_data.
REQ-022 wb_valid SHALL clear pending[wb_rd] at the edge.
REQ-023 If a clear and a set of the same register occur in one cycle, the set SHALL win.
REQ-024 wb_valid for a register that is not pending SHALL still write the register file; the scoreboard SHALL remain unchanged.

Reset
REQ-025 When rst_n is low, asynchronously: state = IDLE, pending = 0, out_valid = 0, out_rs1_val = out_rs2_val = 0, out_rd = 0, out_rd_wen = 0, instruction register = 0.
REQ-026 Reset mid-operation SHALL discard any latched or held instruction with no writeback issued.
REQ-027 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, REG_ADDR_W = 5, and XLEN.
REQ-029 The scoreboard SHALL be one sub-module, scoreboard (set/clear/query ports, set-wins rule); the FSM, bypass and handshake SHALL stay in operand_fetch.

Verification
REQ-030 Case: reset, x3 = 0x11, x4 = 0x22 preloaded; issue rs1=3, rs2=4, rd=5, wen=1. Required: out_rs1_val = 0x11, out_rs2_val = 0x22, one cycle after accept; pending[5] = 1.
REQ-031 Case: hold wb. Issue rs1=5 while pending[5] = 1. Required: out_valid stays 0. Then wb_valid, rd=5, data 0xDEAD. Required: same edge gives out_rs1_val = 0xDEAD (bypass); pending[5] = 0.
REQ-032 Case: rs1=0, rs2=0, rd=0, wen=1. Required: operands 0 and pending unchanged; wb_rd=0 gives rf_write_enable = 0.
REQ-033 Case: WAW. Issue rd=7 twice without wb. Required: second instruction stalls until wb_rd=7, then proceeds with pending[7] = 1 (set wins).
REQ-034 Case: out_ready held 0 for 3 cycles. Required: outputs stable and in_ready = 0. Then out_ready = 1 with in_valid. Required: back-to-back acceptance.
REQ-035 Case: assert rst_n = 0 during STALL and during HOLD. Required: out_valid = 0 immediately and pending = 0; the next instruction executes normally.
